// File: rtl/qam16_pkg.sv
// Shared types for the 16QAM deframer: FSM states, nibble and FIFO-entry types,
// default sync word and a helper that picks one nibble out of the sync word.
// No ports; imported by the deframer top and its testbench.
package qam16_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [15:0] DEF_SYNC_WORD = 16'h1ACF;

  typedef logic [3:0] nibble_t;

  typedef struct packed {
    logic       first;
    logic [7:0] data;
  } fifo_entry_t;

  // Nibble idx of the sync word, MS nibble first (idx 0 -> bits 15:12).
  function automatic nibble_t sync_nibble(input logic [15:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[15:12];
      2'd1:    return word[11:8];
      2'd2:    return word[7:4];
      default: return word[3:0];
    endcase
  endfunction

endpackage

// File: rtl/qam16_deframer_if.sv
// Symbol-in / byte-out bundle of the 16QAM deframer.
// Ports: sym_en, sym_i, sym_q, byte_ready toward the deframer;
//        byte_data, byte_first, byte_valid from the deframer.
interface qam16_deframer_if;
  logic       sym_en;
  logic [1:0] sym_i;
  logic [1:0] sym_q;
  logic [7:0] byte_data;
  logic       byte_first;
  logic       byte_valid;
  logic       byte_ready;

  // master: demod rails plus byte sink; slave: the deframer itself
  modport master (
    output sym_en, sym_i, sym_q, byte_ready,
    input  byte_data, byte_first, byte_valid
  );
  modport slave (
    input  sym_en, sym_i, sym_q, byte_ready,
    output byte_data, byte_first, byte_valid
  );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head is visible combinationally while non-empty.
// Ports: clk, rst_n, push/push_dat, pop/pop_dat, full, empty.
// A push while full is accepted only together with a pop; otherwise ignored.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_pop, do_push;

  // extra pointer MSB distinguishes full from empty
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // zero while empty so the output never shows stale or uninitialised data
  assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// File: rtl/qam16_deframer.sv
// 16QAM deframer: merges I/Q 2-bit symbols into nibbles, hunts a 16-bit sync word,
// packs payload nibbles into bytes and holds lock through a sync-miss flywheel.
// Ports: clk_symbol, rst_n, bus (slave: sym_* in, byte_* out), locked, overflow.
module qam16_deframer
  import qam16_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD     = DEF_SYNC_WORD,
  parameter int          PAYLOAD_BYTES = 4,
  parameter int          LOCK_MISSES   = 2,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic              clk_symbol,
  input  logic              rst_n,
  qam16_deframer_if.slave   bus,
  output logic              locked,
  output logic              overflow
);
  localparam logic [8:0] NIB_LAST = 9'(2 * PAYLOAD_BYTES - 1);
  localparam logic [3:0] MISS_LIM = 4'(LOCK_MISSES);

  state_t      state_q, state_d;
  // Only the three most recent nibbles are kept; the fourth sync nibble is the live input.
  logic [11:0] sync_sr;
  logic [8:0]  nib_cnt;
  logic [2:0]  miss_cnt;
  logic [1:0]  chk_idx;
  logic        chk_bad, bad_now;
  nibble_t     nibble, hi_nib;
  logic        push, pop, fifo_full, fifo_empty, last_nib;
  fifo_entry_t push_ent;
  logic [8:0]  head;

  assign nibble   = {bus.sym_i, bus.sym_q};
  assign last_nib = (nib_cnt == NIB_LAST);
  assign bad_now  = chk_bad | (nibble != sync_nibble(SYNC_WORD, chk_idx));
  assign locked   = (state_q != HUNT);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    if (bus.sym_en) begin
      case (state_q)
        HUNT:    if ({sync_sr, nibble} == SYNC_WORD) state_d = PAYLOAD;
        PAYLOAD: begin
          push = nib_cnt[0];
          if (last_nib) state_d = CHECK;
        end
        CHECK:   if (chk_idx == 2'd3) begin
          // flywheel: a bad sync still delivers the next frame until the miss budget is spent
          if (!bad_now || (({1'b0, miss_cnt} + 4'd1) < MISS_LIM)) state_d = PAYLOAD;
          else                                                    state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_symbol or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      sync_sr  <= '0;
      nib_cnt  <= '0;
      miss_cnt <= '0;
      chk_idx  <= '0;
      chk_bad  <= 1'b0;
      hi_nib   <= '0;
    end else begin
      state_q <= state_d;
      if (bus.sym_en) begin
        // a fresh hunt must not match on nibbles left over from the lost frame
        sync_sr <= (state_q != HUNT && state_d == HUNT) ? '0 : {sync_sr[7:0], nibble};
        case (state_q)
          HUNT: if (state_d == PAYLOAD) begin
            nib_cnt  <= '0;
            miss_cnt <= '0;
          end
          PAYLOAD: begin
            if (!nib_cnt[0]) hi_nib <= nibble;
            if (last_nib) begin
              chk_idx <= '0;
              chk_bad <= 1'b0;
            end else begin
              nib_cnt <= nib_cnt + 9'd1;
            end
          end
          CHECK: begin
            if (chk_idx == 2'd3) begin
              nib_cnt <= '0;
              chk_idx <= '0;
              chk_bad <= 1'b0;
              if (!bad_now)                miss_cnt <= '0;
              else if (state_d == PAYLOAD) miss_cnt <= miss_cnt + 3'd1;
            end else begin
              chk_idx <= chk_idx + 2'd1;
              chk_bad <= bad_now;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign push_ent.first = (nib_cnt == 9'd1);
  assign push_ent.data  = {hi_nib, nibble};
  assign pop            = !fifo_empty && bus.byte_ready;

  // The deframer never waits on the sink; a push into a full FIFO without a pop is lost.
  always_ff @(posedge clk_symbol or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= push && fifo_full && !pop;
  end

  sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk_symbol),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.byte_first = head[8];
  assign bus.byte_data  = head[7:0];
  assign bus.byte_valid = !fifo_empty;
endmodule
